pe_ld_unit_arbiter: RTL

Shares one memory load port (ld unit) between N_REQ PE functional-unit load requesters. Each cycle it picks one requester round-robin, forwards its address to the memory unit and records the requester ID in an in-order tracking FIFO. When the in-order load response returns, it routes the response to that requester. It sits between the per-func-unit ld flow-control interfaces and the shared memory unit, and bounds the number of outstanding loads.

---
 rtl/pe_ld_arb_pkg.sv | 19 +
 rtl/pe_ld_unit_arbiter_if.sv | 34 +++
 rtl/pe_ld_id_fifo.sv | 49 ++++
 rtl/pe_ld_unit_arbiter.sv | 101 ++++++++++
 4 files changed

// File: rtl/pe_ld_arb_pkg.sv
// Shared sizing helpers and types for the PE load-unit arbiter.
package pe_ld_arb_pkg;

  localparam int unsigned N_REQ_DEF   = 4;
  localparam int unsigned ADDR_W_DEF  = 16;
  localparam int unsigned DATA_W_DEF  = 32;
  localparam int unsigned MAX_OUT_DEF = 4;

  // A requester ID needs at least one bit even when only one requester exists.
  function automatic int unsigned id_width(input int unsigned n);
    return (n > 1) ? int'($clog2(n)) : 1;
  endfunction

  localparam int unsigned ID_W  = id_width(N_REQ_DEF);
  localparam int unsigned CNT_W = $clog2(MAX_OUT_DEF + 1);

  typedef logic [ID_W-1:0] req_id_t;

endpackage

// File: rtl/pe_ld_unit_arbiter_if.sv
// Bundle of requester, memory-unit and status signals around the load arbiter.
interface pe_ld_unit_arbiter_if #(
  parameter int unsigned N_REQ   = 4,
  parameter int unsigned ADDR_W  = 16,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned MAX_OUT = 4
);
  localparam int unsigned CntW = $clog2(MAX_OUT + 1);

  logic [N_REQ-1:0]        req_vld;
  logic [N_REQ*ADDR_W-1:0] req_addr;
  logic [N_REQ-1:0]        gnt;
  logic                    mem_req_vld;
  logic [ADDR_W-1:0]       mem_req_addr;
  logic                    mem_req_rdy;
  logic                    mem_rsp_vld;
  logic [DATA_W-1:0]       mem_rsp_data;
  logic [N_REQ-1:0]        rsp_vld;
  logic [DATA_W-1:0]       rsp_data;
  logic [CntW-1:0]         outstanding;
  logic                    idle;
  logic                    err_spurious;

  modport slave (
    input  req_vld, req_addr, mem_req_rdy, mem_rsp_vld, mem_rsp_data,
    output gnt, mem_req_vld, mem_req_addr, rsp_vld, rsp_data, outstanding, idle, err_spurious
  );

  modport master (
    output req_vld, req_addr, mem_req_rdy, mem_rsp_vld, mem_rsp_data,
    input  gnt, mem_req_vld, mem_req_addr, rsp_vld, rsp_data, outstanding, idle, err_spurious
  );

endinterface

// File: rtl/pe_ld_id_fifo.sv
// In-order tracking FIFO of requester IDs; the occupancy count is the outstanding-load count.
module pe_ld_id_fifo #(
  parameter  int unsigned Depth = 4,
  parameter  int unsigned IdW   = 2,
  localparam int unsigned PtrW  = (Depth > 1) ? $clog2(Depth) : 1,
  localparam int unsigned CntW  = $clog2(Depth + 1)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            push,
  input  logic [IdW-1:0]  push_id,
  input  logic            pop,
  output logic [IdW-1:0]  head_id,
  output logic            full,
  output logic            empty,
  output logic [CntW-1:0] count
);

  logic [IdW-1:0]  mem_q [Depth];
  logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0] count_q;

  // Explicit wrap so Depth need not be a power of two.
  function automatic logic [PtrW-1:0] wrap_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(Depth - 1)) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wrap_inc(wr_ptr_q);
      if (pop)  rd_ptr_q <= wrap_inc(rd_ptr_q);
      count_q <= count_q + CntW'(push) - CntW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= push_id;
  end

  assign head_id = mem_q[rd_ptr_q];
  assign full    = (count_q == CntW'(Depth));
  assign empty   = (count_q == '0);
  assign count   = count_q;

endmodule

// File: rtl/pe_ld_unit_arbiter.sv
// Round-robin sharing of one memory load port among N_REQ requesters, with in-order
// response routing back to the requester that issued each load.
module pe_ld_unit_arbiter
  import pe_ld_arb_pkg::*;
#(
  parameter int unsigned N_REQ   = N_REQ_DEF,
  parameter int unsigned ADDR_W  = ADDR_W_DEF,
  parameter int unsigned DATA_W  = DATA_W_DEF,
  parameter int unsigned MAX_OUT = MAX_OUT_DEF
) (
  input logic                 clk,
  input logic                 rst,
  pe_ld_unit_arbiter_if.slave bus
);

  localparam int unsigned IdW  = id_width(N_REQ);
  localparam int unsigned CntW = $clog2(MAX_OUT + 1);

  logic [IdW-1:0]   rr_ptr_q, sel, head_id;
  logic [N_REQ-1:0] gnt, rsp_vld;
  logic [CntW-1:0]  count;
  logic             any_req, mem_vld, full, empty, push, pop, err_q;

  function automatic logic [IdW-1:0] rr_pick(input logic [N_REQ-1:0] vld,
                                             input logic [IdW-1:0]   ptr);
    logic [IdW-1:0] pick;
    logic           found;
    int unsigned    idx;
    pick  = '0;
    found = 1'b0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      idx = (32'(ptr) + k) % N_REQ;
      if (!found && vld[idx]) begin
        found = 1'b1;
        pick  = IdW'(idx);
      end
    end
    return pick;
  endfunction

  assign any_req = |bus.req_vld;
  assign sel     = rr_pick(bus.req_vld, rr_ptr_q);
  // Full comes from the registered count, so a same-cycle pop never frees a slot.
  assign mem_vld = any_req & ~full;
  assign push    = mem_vld & bus.mem_req_rdy;
  assign pop     = bus.mem_rsp_vld & ~empty;

  always_comb begin
    gnt     = '0;
    rsp_vld = '0;
    if (push) gnt[sel]         = 1'b1;
    if (pop)  rsp_vld[head_id] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr_q <= '0;
      err_q    <= 1'b0;
    end else begin
      if (push) rr_ptr_q <= (sel == IdW'(N_REQ - 1)) ? '0 : sel + 1'b1;
      if (bus.mem_rsp_vld && empty) err_q <= 1'b1;
    end
  end

  pe_ld_id_fifo #(
    .Depth (MAX_OUT),
    .IdW   (IdW)
  ) u_id_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (push),
    .push_id (sel),
    .pop     (pop),
    .head_id (head_id),
    .full    (full),
    .empty   (empty),
    .count   (count)
  );

  assign bus.gnt          = gnt;
  assign bus.mem_req_vld  = mem_vld;
  assign bus.mem_req_addr = any_req ? bus.req_addr[sel*ADDR_W +: ADDR_W] : '0;
  assign bus.rsp_vld      = rsp_vld;
  assign bus.rsp_data     = bus.mem_rsp_data;
  assign bus.outstanding  = count;
  assign bus.idle         = (count == '0);
  assign bus.err_spurious = err_q;

  gnt_onehot_a: assert property (@(posedge clk) disable iff (rst) $onehot0(gnt));
  gnt_has_req_a: assert property (@(posedge clk) disable iff (rst) (gnt & ~bus.req_vld) == '0);
  no_push_full_a: assert property (@(posedge clk) disable iff (rst) push |-> !full);
  rsp_onehot_a: assert property (@(posedge clk) disable iff (rst) $onehot0(rsp_vld));
  spurious_flag_a: assert property (@(posedge clk) disable iff (rst)
    (bus.mem_rsp_vld && empty) |=> err_q);

  for (genvar i = 0; i < N_REQ; i++) begin : g_addr_stable
    addr_stable_a: assert property (@(posedge clk) disable iff (rst)
      (bus.req_vld[i] && !gnt[i]) |=> $stable(bus.req_addr[i*ADDR_W +: ADDR_W]));
  end

endmodule
